// File: rtl/bcd_counter_ctrl.sv
// Command-driven controller for an external 3-digit BCD counter: prescaled count
// ticks, target match with optional auto-halt, sticky overflow and load-error flags.
module bcd_counter_ctrl #(
   parameter int unsigned PRESCALE     = 10,
   parameter bit          AUTO_STOP    = 1'b1,
   parameter logic [11:0] RESET_TARGET = 12'h999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [11:0] cmd_target,
   input  logic [3:0]  ones,
   input  logic [3:0]  tens,
   input  logic [3:0]  hundreds,
   input  logic        counter_done,
   output logic        cnt_enable,
   output logic        cnt_clear,
   output logic [1:0]  state,
   output logic        match,
   output logic        overflow,
   output logic        load_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10,
      S_HALT   = 2'b11
   } state_t;

   localparam logic [1:0]  OP_START = 2'b00;
   localparam logic [1:0]  OP_STOP  = 2'b01;
   localparam logic [1:0]  OP_CLEAR = 2'b10;
   localparam logic [1:0]  OP_LOAD  = 2'b11;
   localparam logic [15:0] PS_LAST  = 16'(PRESCALE - 1);

   state_t      state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic [11:0] target_q, target_d;
   logic        eval_q;
   logic        cnt_enable_d, cnt_clear_d, match_d, overflow_d, load_err_d;
   logic        fire, op_start, op_stop, op_clear, op_load, load_ok, hit;

   assign fire     = cmd_valid & cmd_ready;
   assign op_start = fire && (cmd_op == OP_START);
   assign op_stop  = fire && (cmd_op == OP_STOP);
   assign op_clear = fire && (cmd_op == OP_CLEAR);
   assign op_load  = fire && (cmd_op == OP_LOAD);
   assign load_ok  = (cmd_target[3:0] <= 4'd9) && (cmd_target[7:4] <= 4'd9) &&
                     (cmd_target[11:8] <= 4'd9);
   // eval_q marks the cycle after a tick, when the counter digits have settled
   assign hit      = eval_q && ({hundreds, tens, ones} == target_q);
   assign state    = state_q;

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      target_d     = target_q;
      cnt_enable_d = 1'b0;
      cnt_clear_d  = 1'b0;
      match_d      = 1'b0;
      overflow_d   = overflow | (cnt_enable & counter_done);
      load_err_d   = load_err;

      case (state_q)
         S_IDLE: begin
            if (op_start) begin
               state_d = S_RUN;
               presc_d = '0;
            end else if (op_clear) begin
               cnt_clear_d = 1'b1;
            end
         end
         S_RUN: begin
            if (op_stop) begin
               state_d = S_PAUSED;
            end else if (op_clear) begin
               cnt_clear_d = 1'b1;
               presc_d     = '0;
            end else if (presc_q == PS_LAST) begin
               cnt_enable_d = 1'b1;
               presc_d      = '0;
            end else begin
               presc_d = presc_q + 16'd1;
            end
         end
         S_PAUSED: begin
            if (op_start) begin
               state_d = S_RUN;
            end else if (op_clear) begin
               cnt_clear_d = 1'b1;
               state_d     = S_IDLE;
               presc_d     = '0;
            end
         end
         S_HALT: begin
            if (op_clear) begin
               cnt_clear_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A same-cycle STOP or CLEAR outranks the auto-halt; CLEAR also kills the pulse
      if (hit && !op_clear) begin
         match_d = 1'b1;
         if (AUTO_STOP && (state_q == S_RUN) && (state_d == S_RUN)) begin
            state_d      = S_HALT;
            cnt_enable_d = 1'b0;
         end
      end

      if (op_load) begin
         if (load_ok) target_d   = cmd_target;
         else         load_err_d = 1'b1;
      end

      if (op_clear) begin
         overflow_d = 1'b0;
         load_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         presc_q    <= '0;
         target_q   <= RESET_TARGET;
         eval_q     <= 1'b0;
         cnt_enable <= 1'b0;
         cnt_clear  <= 1'b1;
         match      <= 1'b0;
         overflow   <= 1'b0;
         load_err   <= 1'b0;
         cmd_ready  <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         target_q   <= target_d;
         eval_q     <= cnt_enable;
         cnt_enable <= cnt_enable_d;
         cnt_clear  <= cnt_clear_d;
         match      <= match_d;
         overflow   <= overflow_d;
         load_err   <= load_err_d;
         // the counter is busy clearing, so no command is taken that cycle
         cmd_ready  <= ~cnt_clear_d;
      end
   end

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Bench for bcd_counter_ctrl: an auto-halt and a free-running instance share the command
// stream; each drives its own behavioural BCD counter and is compared to a decimal model.
module tb_bcd_counter_ctrl;

   localparam int P = 4;
   localparam int IDLE = 0, RUN = 1, PAUSED = 2, HALT = 3;
   localparam int START = 0, STOP = 1, CLEAR = 2, LOAD = 3;

   logic clk = 1'b0;
   logic reset;
   logic cmd_valid;
   logic [1:0] cmd_op;
   logic [11:0] cmd_target;
   logic [1:0] cmd_ready, cnt_enable, cnt_clear, match, overflow, load_err, counter_done;
   logic [1:0][1:0] state;
   logic [1:0][3:0] ones, tens, hundreds;

   int n_chk = 0, n_pass = 0;
   int env_val[2];

   // reference model: decimal counter value and target, mode numbered as the state port
   int m_mode[2], m_phase[2], m_target[2], m_val[2];
   bit m_en[2], m_clr[2], m_match[2], m_ovf[2], m_lerr[2], m_rdy[2], m_prev_en[2];

   always #5 clk = ~clk;

   bcd_counter_ctrl #(.PRESCALE(P), .AUTO_STOP(1'b1)) dut_halt (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
      .cmd_op(cmd_op), .cmd_target(cmd_target), .ones(ones[0]), .tens(tens[0]),
      .hundreds(hundreds[0]), .counter_done(counter_done[0]), .cnt_enable(cnt_enable[0]),
      .cnt_clear(cnt_clear[0]), .state(state[0]), .match(match[0]),
      .overflow(overflow[0]), .load_err(load_err[0]));

   bcd_counter_ctrl #(.PRESCALE(P), .AUTO_STOP(1'b0)) dut_free (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
      .cmd_op(cmd_op), .cmd_target(cmd_target), .ones(ones[1]), .tens(tens[1]),
      .hundreds(hundreds[1]), .counter_done(counter_done[1]), .cnt_enable(cnt_enable[1]),
      .cnt_clear(cnt_clear[1]), .state(state[1]), .match(match[1]),
      .overflow(overflow[1]), .load_err(load_err[1]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   function automatic bit bcd_ok(input logic [11:0] t);
      return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd9) && (t[11:8] <= 4'd9);
   endfunction

   function automatic int dec_of(input logic [11:0] t);
      return int'(t[11:8]) * 100 + int'(t[7:4]) * 10 + int'(t[3:0]);
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic drive_digits(input int k);
      {hundreds[k], tens[k], ones[k]} = to_bcd(env_val[k]);
      counter_done[k] = (env_val[k] == 999);
   endtask

   task automatic preset(input int v);
      for (int k = 0; k < 2; k++) begin
         env_val[k] = v;
         m_val[k]   = v;
         drive_digits(k);
      end
   endtask

   // predicts every registered output after the coming edge from the current inputs
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int nm, np, nv, nt;
         bit fire, hit, ne, nc, nmt, novf, nlerr, clr_cmd;
         nv = m_clr[k] ? 0 : (m_en[k] ? (m_val[k] + 1) % 1000 : m_val[k]);
         if (reset) begin
            m_mode[k] = IDLE; m_phase[k] = 0; m_target[k] = 999;
            m_en[k] = 0; m_clr[k] = 1; m_match[k] = 0; m_ovf[k] = 0;
            m_lerr[k] = 0; m_rdy[k] = 0; m_prev_en[k] = 0;
         end else begin
            fire    = cmd_valid && m_rdy[k];
            clr_cmd = fire && (int'(cmd_op) == CLEAR);
            hit     = m_prev_en[k] && (m_val[k] == m_target[k]);
            nm = m_mode[k]; np = m_phase[k]; nt = m_target[k];
            ne = 0; nc = 0; nmt = 0;
            novf  = m_ovf[k] || (m_en[k] && m_val[k] == 999);
            nlerr = m_lerr[k];
            if (fire) begin
               case (int'(cmd_op))
                  START: if (m_mode[k] == IDLE) begin nm = RUN; np = 0; end
                         else if (m_mode[k] == PAUSED) nm = RUN;
                  STOP:  if (m_mode[k] == RUN) nm = PAUSED;
                  CLEAR: begin
                     nc = 1; np = 0; novf = 0; nlerr = 0;
                     if (m_mode[k] != RUN) nm = IDLE;
                  end
                  default: if (bcd_ok(cmd_target)) nt = dec_of(cmd_target); else nlerr = 1;
               endcase
            end
            if (m_mode[k] == RUN && nm == RUN && !nc) begin
               if (m_phase[k] == P - 1) begin ne = 1; np = 0; end
               else np = m_phase[k] + 1;
            end
            if (hit && !clr_cmd) begin
               nmt = 1;
               if (k == 0 && m_mode[k] == RUN && nm == RUN) begin nm = HALT; ne = 0; end
            end
            m_prev_en[k] = m_en[k];
            m_mode[k] = nm; m_phase[k] = np; m_target[k] = nt;
            m_en[k] = ne; m_clr[k] = nc; m_match[k] = nmt;
            m_ovf[k] = novf; m_lerr[k] = nlerr; m_rdy[k] = !nc;
         end
         m_val[k] = nv;
      end
   endtask

   // one clock: model predicts, edge, external counters react, outputs compared
   task automatic cycle();
      bit en_s[2], clr_s[2];
      for (int k = 0; k < 2; k++) begin
         en_s[k]  = (cnt_enable[k] === 1'b1);
         clr_s[k] = (cnt_clear[k] === 1'b1);
      end
      model_step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (clr_s[k])     env_val[k] = 0;
         else if (en_s[k]) env_val[k] = (env_val[k] + 1) % 1000;
         drive_digits(k);
         chk($sformatf("dut%0d_outputs", k),
             {cmd_ready[k], cnt_enable[k], cnt_clear[k], state[k], match[k], overflow[k], load_err[k]},
             {m_rdy[k], m_en[k], m_clr[k], 2'(m_mode[k]), m_match[k], m_ovf[k], m_lerr[k]});
      end
   endtask

   task automatic do_cmd(input int op, input logic [11:0] tgt);
      int w = 0;
      while (cmd_ready[0] !== 1'b1 && w < 10) begin cycle(); w++; end
      if (w == 10) chk("ready_timeout", cmd_ready[0], 1);
      cmd_valid = 1'b1; cmd_op = 2'(op); cmd_target = tgt;
      cycle();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, w, t3, mpos, r;
      int pos[$];
      logic [11:0] tgt;

      reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'(START); cmd_target = '0;
      for (int k = 0; k < 2; k++) begin
         env_val[k] = 0; m_val[k] = 0; drive_digits(k);
      end
      cycle(); cycle();
      chk("rst_state", state[0], IDLE);
      chk("rst_clear", cnt_clear[0], 1);
      chk("rst_ready", cmd_ready[0], 0);
      reset = 1'b0; cmd_valid = 1'b0;
      cycle();
      chk("post_rst_ready", cmd_ready[0], 1);
      chk("post_rst_clear", cnt_clear[0], 0);

      // tick spacing from IDLE START
      do_cmd(START, '0);
      for (int i = 1; i <= 13; i++) begin
         cycle();
         if (cnt_enable[0]) pos.push_back(i);
      end
      chk("tick_count", pos.size(), 3);
      for (int j = 0; j < 3; j++)
         chk($sformatf("tick%0d_cycle", j + 1), (j < pos.size()) ? pos[j] : -1, 4 * (j + 1));

      // pause at prescaler 2, resume two cycles before the tick
      cycle();
      do_cmd(STOP, '0);
      chk("stop_state", state[0], PAUSED);
      n = 0;
      repeat (20) begin cycle(); if (cnt_enable[0]) n++; end
      chk("paused_ticks", n, 0);
      do_cmd(START, '0);
      n = 0;
      while (!cnt_enable[0] && n < 20) begin cycle(); n++; end
      chk("resume_latency", n, 2);

      // illegal load leaves the 999 target in place
      do_cmd(LOAD, 12'h0A5);
      chk("load_err_set", load_err[0], 1);
      do_cmd(STOP, '0);
      do_cmd(CLEAR, '0);
      chk("paused_clear_pulse", cnt_clear[0], 1);
      chk("paused_clear_idle", state[0], IDLE);
      chk("load_err_cleared", load_err[0], 0);
      cycle();
      preset(996);
      do_cmd(START, '0);
      n = 0;
      while (state[0] != 2'(HALT) && n < 40) begin cycle(); n++; end
      chk("halt_at_999", state[0], HALT);
      chk("halt_match", match[0], 1);
      chk("free_match", match[1], 1);
      chk("free_keeps_run", state[1], RUN);
      n = 0; w = 0;
      while (!overflow[1] && w < 20) begin cycle(); w++; if (cnt_enable[0]) n++; end
      repeat (8) begin cycle(); if (cnt_enable[0]) n++; end
      chk("ovf_sticky", overflow[1], 1);
      chk("halted_no_ovf", overflow[0], 0);
      chk("halted_no_tick", n, 0);
      do_cmd(CLEAR, '0);
      chk("clr_pulse", cnt_clear[1], 1);
      chk("clr_ready_low", cmd_ready[1], 0);
      chk("clr_ovf", overflow[1], 0);
      chk("halt_to_idle", state[0], IDLE);
      cycle();

      // target 003 reached after third tick, then auto-halt
      do_cmd(LOAD, 12'h003);
      do_cmd(START, '0);
      n = 0; t3 = -100; mpos = -1;
      for (int i = 1; i <= 40 && mpos < 0; i++) begin
         cycle();
         if (cnt_enable[0]) begin n++; if (n == 3) t3 = i; end
         if (match[0]) mpos = i;
      end
      chk("ticks_to_match", n, 3);
      chk("match_delay", mpos - t3, 2);
      chk("auto_halt", state[0], HALT);
      n = 0;
      repeat (20) begin cycle(); if (cnt_enable[0]) n++; end
      chk("halt_quiet", n, 0);

      // CLEAR during the evaluation cycle suppresses the match
      do_cmd(CLEAR, '0);
      cycle();
      do_cmd(START, '0);
      n = 0; w = 0;
      while (n < 3 && w < 40) begin cycle(); w++; if (cnt_enable[0]) n++; end
      cycle();
      do_cmd(CLEAR, '0);
      chk("clr_eval_nomatch", match[0], 0);
      chk("clr_eval_run", state[0], RUN);
      cycle();
      reset = 1'b1;
      cycle();
      chk("rst_in_run", state[0], IDLE);
      reset = 1'b0;
      cycle();

      // randomized traffic against the model
      for (int it = 0; it < 3000; it++) begin
         reset     = ($urandom_range(0, 199) == 0);
         cmd_valid = ($urandom_range(0, 4) == 0);
         r = $urandom_range(0, 9);
         cmd_op = (r < 4) ? 2'(START) : (r < 6) ? 2'(STOP) : (r < 7) ? 2'(CLEAR) : 2'(LOAD);
         r = $urandom_range(0, 9);
         if (r < 4)      tgt = to_bcd($urandom_range(0, 9));
         else if (r < 6) tgt = to_bcd($urandom_range(990, 999));
         else if (r < 8) tgt = 12'($urandom);
         else            tgt = to_bcd($urandom_range(0, 999));
         cmd_target = tgt;
         if ($urandom_range(0, 149) == 0) preset($urandom_range(994, 999));
         cycle();
      end
      cmd_valid = 1'b0;
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
